// File: rtl/apb_slave_regfile_pkg.sv
// rtl/apb_slave_regfile_pkg.sv - shared types, defaults and helpers for apb_slave_regfile
package apb_slave_regfile_pkg;

   typedef enum logic {
      IDLE   = 1'b0,
      ACCESS = 1'b1
   } state_t;

   localparam int DEF_DATA_WIDTH  = 32;
   localparam int DEF_ADDR_WIDTH  = 8;
   localparam int DEF_NUM_REGS    = 16;
   localparam int DEF_WAIT_CYCLES = 0;

   // Number of PADDR bits that select a byte within one register word.
   function automatic int byte_offset_bits(input int dw);
      return (dw == 64) ? 3 : (dw == 32) ? 2 : (dw == 16) ? 1 : 0;
   endfunction

endpackage

// File: rtl/apb_regfile_mem.sv
// rtl/apb_regfile_mem.sv - register storage, byte-masked sync write, async read
module apb_regfile_mem #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_BITS  = 4
) (
   input  logic                    i_clk,
   input  logic                    i_resetn,
   input  logic                    i_we,
   input  logic [ADDR_BITS-1:0]    i_waddr,
   input  logic [DATA_WIDTH-1:0]   i_wdata,
   input  logic [DATA_WIDTH/8-1:0] i_wmask,
   input  logic [ADDR_BITS-1:0]    i_raddr,
   output logic [DATA_WIDTH-1:0]   o_rdata
);

   localparam int NB    = DATA_WIDTH / 8;
   localparam int DEPTH = 1 << ADDR_BITS;

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];

   // Clear all words on reset; otherwise update the enabled byte lanes of one word.
   always_ff @(posedge i_clk) begin
      if (!i_resetn) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else if (i_we) begin
         for (int b = 0; b < NB; b++) begin
            if (i_wmask[b]) begin
               r_mem[i_waddr][b*8 +: 8] <= i_wdata[b*8 +: 8];
            end
         end
      end
   end

   assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/apb_slave_regfile.sv
// rtl/apb_slave_regfile.sv - APB completer with register file, wait states, PSLVERR; option APB_SLV_PSTRB_EN
module apb_slave_regfile
   import apb_slave_regfile_pkg::*;
#(
   parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
   parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
   parameter int NUM_REGS    = DEF_NUM_REGS,
   parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
   input  logic                    PCLK,
   input  logic                    PRESETn,
   input  logic                    PSEL,
   input  logic                    PENABLE,
   input  logic                    PWRITE,
   input  logic [ADDR_WIDTH-1:0]   PADDR,
   input  logic [DATA_WIDTH-1:0]   PWDATA,
`ifdef APB_SLV_PSTRB_EN
   input  logic [DATA_WIDTH/8-1:0] PSTRB,
`endif
   output logic [DATA_WIDTH-1:0]   PRDATA,
   output logic                    PREADY,
   output logic                    PSLVERR
);

   localparam int NB     = DATA_WIDTH / 8;
   localparam int OFFS   = byte_offset_bits(DATA_WIDTH);
   localparam int IDX_W  = ADDR_WIDTH - OFFS;
   localparam int MEM_AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
   localparam logic [ADDR_WIDTH-1:0] OFFS_MASK = ADDR_WIDTH'((1 << OFFS) - 1);

   state_t                  r_state;
   state_t                  w_state_nxt;
   logic [3:0]              r_cnt;
   logic                    r_write;
   logic                    r_err;
   logic [MEM_AW-1:0]       r_addr;
   logic [DATA_WIDTH-1:0]   r_wdata;
   logic [DATA_WIDTH-1:0]   r_prdata;
   logic [NB-1:0]           w_mask;

   logic [IDX_W-1:0]        w_idx;
   logic                    w_setup_err;
   logic                    w_setup;
   logic                    w_ready;
   logic                    w_commit;
   logic [DATA_WIDTH-1:0]   w_mem_rdata;

   assign w_idx       = IDX_W'(PADDR >> OFFS);
   assign w_setup_err = ((PADDR & OFFS_MASK) != '0) || (32'(w_idx) >= 32'(NUM_REGS));
   assign w_setup     = (r_state == IDLE) && PSEL && !PENABLE;
   assign w_ready     = (r_state == ACCESS) && (r_cnt == 4'd0);
   assign w_commit    = w_ready && PSEL && PENABLE && r_write && !r_err;

`ifdef APB_SLV_PSTRB_EN
   logic [NB-1:0] r_strb;

   // Strobes are captured with the rest of the setup phase and applied at commit.
   always_ff @(posedge PCLK) begin
      if (!PRESETn) begin
         r_strb <= '0;
      end else if (w_setup) begin
         r_strb <= PSTRB;
      end
   end

   assign w_mask = r_strb;
`else
   assign w_mask = '1;
`endif

   apb_regfile_mem #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_BITS  (MEM_AW)
   ) u_mem (
      .i_clk    (PCLK),
      .i_resetn (PRESETn),
      .i_we     (w_commit),
      .i_waddr  (r_addr),
      .i_wdata  (r_wdata),
      .i_wmask  (w_mask),
      .i_raddr  (MEM_AW'(w_idx)),
      .o_rdata  (w_mem_rdata)
   );

   // State register plus setup-phase capture and wait-state countdown.
   always_ff @(posedge PCLK) begin
      if (!PRESETn) begin
         r_state  <= IDLE;
         r_cnt    <= '0;
         r_write  <= 1'b0;
         r_err    <= 1'b0;
         r_addr   <= '0;
         r_wdata  <= '0;
         r_prdata <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_setup) begin
            r_write <= PWRITE;
            r_err   <= w_setup_err;
            r_addr  <= MEM_AW'(w_idx);
            r_wdata <= PWDATA;
            r_cnt   <= 4'(WAIT_CYCLES);
            if (!PWRITE) begin
               r_prdata <= w_setup_err ? '0 : w_mem_rdata;
            end
         end else if ((r_state == ACCESS) && (r_cnt != 4'd0)) begin
            r_cnt <= r_cnt - 4'd1;
         end
      end
   end

   // Next state: setup enters ACCESS; completion or a dropped PSEL returns to IDLE.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (PSEL && !PENABLE) w_state_nxt = ACCESS;
         ACCESS:  if (!PSEL || (w_ready && PENABLE)) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   assign PRDATA  = r_prdata;
   assign PREADY  = w_ready;
   assign PSLVERR = w_ready && r_err;

endmodule

// File: tb/tb_apb_slave_regfile.sv
// tb/tb_apb_slave_regfile.sv - directed self-checking bench for apb_slave_regfile
module tb_apb_slave_regfile;

   logic        PCLK = 1'b0;
   logic        PRESETn;
   logic [2:0]  psel;
   logic        PENABLE;
   logic        PWRITE;
   logic [7:0]  PADDR;
   logic [31:0] PWDATA;
`ifdef APB_SLV_PSTRB_EN
   logic [3:0]  PSTRB;
`endif
   logic [31:0] prdata [3];
   logic [2:0]  pready;
   logic [2:0]  pslverr;

   int n_assert = 0;
   int n_fail   = 0;

   logic [31:0] rd;
   logic        er;
   int          cyc;

   always #5 PCLK = ~PCLK;

   apb_slave_regfile #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .NUM_REGS(16), .WAIT_CYCLES(0)) u_w0 (
      .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(psel[0]), .PENABLE(PENABLE), .PWRITE(PWRITE),
      .PADDR(PADDR), .PWDATA(PWDATA),
`ifdef APB_SLV_PSTRB_EN
      .PSTRB(PSTRB),
`endif
      .PRDATA(prdata[0]), .PREADY(pready[0]), .PSLVERR(pslverr[0]));

   apb_slave_regfile #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .NUM_REGS(16), .WAIT_CYCLES(2)) u_w2 (
      .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(psel[1]), .PENABLE(PENABLE), .PWRITE(PWRITE),
      .PADDR(PADDR), .PWDATA(PWDATA),
`ifdef APB_SLV_PSTRB_EN
      .PSTRB(PSTRB),
`endif
      .PRDATA(prdata[1]), .PREADY(pready[1]), .PSLVERR(pslverr[1]));

   apb_slave_regfile #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .NUM_REGS(16), .WAIT_CYCLES(3)) u_w3 (
      .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(psel[2]), .PENABLE(PENABLE), .PWRITE(PWRITE),
      .PADDR(PADDR), .PWDATA(PWDATA),
`ifdef APB_SLV_PSTRB_EN
      .PSTRB(PSTRB),
`endif
      .PRDATA(prdata[2]), .PREADY(pready[2]), .PSLVERR(pslverr[2]));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // Called at a negedge; drives setup now, returns one negedge after the completing edge.
   task automatic xfer(input int d, input logic wr, input logic [7:0] addr, input logic [31:0] wdata,
                       output logic [31:0] rdata, output logic err, output int cycles);
      psel    = 3'b000;
      psel[d] = 1'b1;
      PENABLE = 1'b0;
      PWRITE  = wr;
      PADDR   = addr;
      PWDATA  = wdata;
      cycles  = 1;
      @(negedge PCLK);
      PENABLE = 1'b1;
      cycles  = 2;
      while (!pready[d] && cycles < 40) begin
         @(negedge PCLK);
         cycles++;
      end
      rdata = prdata[d];
      err   = pslverr[d];
      @(negedge PCLK);
      psel    = 3'b000;
      PENABLE = 1'b0;
   endtask

   task automatic idle();
      psel    = 3'b000;
      PENABLE = 1'b0;
      @(negedge PCLK);
   endtask

   initial begin
      PRESETn = 1'b0;
      psel    = 3'b000;
      PENABLE = 1'b0;
      PWRITE  = 1'b0;
      PADDR   = 8'h00;
      PWDATA  = 32'h0;
`ifdef APB_SLV_PSTRB_EN
      PSTRB   = 4'hF;
`endif
      repeat (2) @(negedge PCLK);
      chk("rst_prdata_w0", prdata[0], 32'h0);
      chk("rst_pready_w0", {31'h0, pready[0]}, 32'h0);
      chk("rst_pslverr_w0", {31'h0, pslverr[0]}, 32'h0);
      chk("rst_pready_w3", {31'h0, pready[2]}, 32'h0);
      PRESETn = 1'b1;
      @(negedge PCLK);

      // Basic write/read, zero wait states
      xfer(0, 1'b1, 8'h04, 32'hDEADBEEF, rd, er, cyc);
      chk("wr04_cycles", 32'(cyc), 32'd2);
      chk("wr04_err", {31'h0, er}, 32'h0);
      xfer(0, 1'b0, 8'h04, 32'h0, rd, er, cyc);
      chk("rd04_cycles", 32'(cyc), 32'd2);
      chk("rd04_data", rd, 32'hDEADBEEF);
      chk("rd04_err", {31'h0, er}, 32'h0);

      // Back-to-back write then read of the same index
      xfer(0, 1'b1, 8'h08, 32'h11223344, rd, er, cyc);
      xfer(0, 1'b0, 8'h08, 32'h0, rd, er, cyc);
      chk("b2b_rd08_data", rd, 32'h11223344);

      // Highest valid index
      xfer(0, 1'b1, 8'h3C, 32'hA5A5A5A5, rd, er, cyc);
      chk("wr3c_err", {31'h0, er}, 32'h0);
      xfer(0, 1'b0, 8'h3C, 32'h0, rd, er, cyc);
      chk("rd3c_data", rd, 32'hA5A5A5A5);

      // Three wait states
      xfer(2, 1'b0, 8'h00, 32'h0, rd, er, cyc);
      chk("w3_rd00_cycles", 32'(cyc), 32'd5);
      chk("w3_rd00_data", rd, 32'h0);
      chk("w3_rd00_err", {31'h0, er}, 32'h0);

      // Error responses: out of range and misaligned
      xfer(0, 1'b1, 8'h40, 32'h12345678, rd, er, cyc);
      chk("wr40_err", {31'h0, er}, 32'h1);
      chk("wr40_cycles", 32'(cyc), 32'd2);
      xfer(0, 1'b1, 8'h06, 32'h87654321, rd, er, cyc);
      chk("wr06_err", {31'h0, er}, 32'h1);
      xfer(0, 1'b0, 8'h04, 32'h0, rd, er, cyc);
      chk("rd04_after_err_data", rd, 32'hDEADBEEF);
      chk("rd04_after_err_err", {31'h0, er}, 32'h0);
      idle();
      chk("prdata_hold", prdata[0], 32'hDEADBEEF);
      chk("idle_pslverr", {31'h0, pslverr[0]}, 32'h0);
      xfer(0, 1'b0, 8'h40, 32'h0, rd, er, cyc);
      chk("rd40_data", rd, 32'h0);
      chk("rd40_err", {31'h0, er}, 32'h1);

`ifdef APB_SLV_PSTRB_EN
      PSTRB = 4'hF;
      xfer(0, 1'b1, 8'h08, 32'hFFFFFFFF, rd, er, cyc);
      PSTRB = 4'b0101;
      xfer(0, 1'b1, 8'h08, 32'h12345678, rd, er, cyc);
      xfer(0, 1'b0, 8'h08, 32'h0, rd, er, cyc);
      chk("strb_rd08_data", rd, 32'hFF34FF78);
      PSTRB = 4'b0000;
      xfer(0, 1'b1, 8'h08, 32'h00000000, rd, er, cyc);
      chk("strb0_err", {31'h0, er}, 32'h0);
      xfer(0, 1'b0, 8'h08, 32'h0, rd, er, cyc);
      chk("strb0_rd08_data", rd, 32'hFF34FF78);
      PSTRB = 4'hF;
`else
      xfer(0, 1'b1, 8'h08, 32'h12345678, rd, er, cyc);
      xfer(0, 1'b0, 8'h08, 32'h0, rd, er, cyc);
      chk("full_rd08_data", rd, 32'h12345678);
`endif

      // Protocol abort: PSEL dropped during ACCESS of a write
      psel    = 3'b010;
      PENABLE = 1'b0;
      PWRITE  = 1'b1;
      PADDR   = 8'h0C;
      PWDATA  = 32'h77777777;
      @(negedge PCLK);
      PENABLE = 1'b1;
      @(negedge PCLK);
      psel    = 3'b000;
      PENABLE = 1'b0;
      @(negedge PCLK);
      chk("abort_pready", {31'h0, pready[1]}, 32'h0);
      xfer(1, 1'b0, 8'h0C, 32'h0, rd, er, cyc);
      chk("abort_rd0c_data", rd, 32'h0);
      chk("abort_rd0c_cycles", 32'(cyc), 32'd4);

      // Reset during ACCESS of a pending write
      xfer(1, 1'b1, 8'h14, 32'h00005555, rd, er, cyc);
      xfer(1, 1'b0, 8'h14, 32'h0, rd, er, cyc);
      chk("w2_rd14_data", rd, 32'h00005555);
      psel    = 3'b010;
      PENABLE = 1'b0;
      PWRITE  = 1'b1;
      PADDR   = 8'h10;
      PWDATA  = 32'h0000AAAA;
      @(negedge PCLK);
      PENABLE = 1'b1;
      @(negedge PCLK);
      PRESETn = 1'b0;
      @(negedge PCLK);
      chk("midrst_prdata", prdata[1], 32'h0);
      chk("midrst_pready", {31'h0, pready[1]}, 32'h0);
      chk("midrst_pslverr", {31'h0, pslverr[1]}, 32'h0);
      PRESETn = 1'b1;
      psel    = 3'b000;
      PENABLE = 1'b0;
      @(negedge PCLK);
      xfer(1, 1'b0, 8'h10, 32'h0, rd, er, cyc);
      chk("postrst_rd10_data", rd, 32'h0);
      xfer(1, 1'b0, 8'h14, 32'h0, rd, er, cyc);
      chk("postrst_rd14_data", rd, 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
